fp_accumulator: RTL and testbench
=================================

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: an FP32 term (a multiplier product) is presented.
REQ-004 SHALL have port in_data, input, 32 bits: IEEE-754 single-precision term.
REQ-005 SHALL have port in_last, input, 1 bit: this term is the final term of the current sum.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-007 SHALL have port acc_valid, output, 1 bit: the completed sum is presented.
REQ-008 SHALL have port acc_data, output, 32 bits: the FP32 sum.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes acc_data.

Function
REQ-010 SHALL use FSM states IDLE, ALIGN, ADD, NORM and DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; a term is accepted when in_valid && in_ready.
REQ-012 On accept, SHALL go IDLE->ALIGN, capturing the term and in_last.
REQ-013 In ALIGN, SHALL right-shift the smaller-exponent mantissa by the exponent difference, keeping guard, round and sticky bits; a difference >=26 reduces that operand to sticky only.
REQ-014 In ADD, SHALL add or subtract the 24-bit significands (hidden bit restored) into a 27-bit result, sign taken from the larger magnitude.
REQ-015 In NORM, SHALL normalise in one cycle using a leading-zero count, apply rounding (REQ-024/025), update the accumulator, then go to DONE if the captured in_last=1, else to IDLE.
REQ-016 Per-term latency from accept to next in_ready SHALL be exactly 4 cycles.
REQ-017 In DONE, SHALL hold acc_valid=1 and a stable acc_data until out_ready=1; on that cycle SHALL clear the accumulator to +0 and return to IDLE.
REQ-018 Inputs with exponent 0 (zero or denormal) SHALL be treated as zero with sign preserved; results below the minimum normal SHALL flush to +0.
REQ-019 Exact cancellation SHALL yield +0 (0x00000000).
REQ-020 Exponent overflow SHALL yield signed infinity (0x7F800000 / 0xFF800000); once infinite, the accumulator SHALL remain infinite until cleared.
REQ-021 A NaN input, or infinities of opposite sign, SHALL yield 0x7FC00000, which is sticky until cleared.
REQ-022 in_valid while not in_ready SHALL be ignored; the producer holds in_data.

Reset
REQ-023 While rst=1, SHALL force state IDLE, accumulator +0, acc_valid=0 and acc_data=0x00000000; in_ready SHALL be 1 in the first cycle after rst deasserts. Reset mid-operation SHALL discard the partial sum.

Configuration
REQ-024 With FP_ACC_ROUND_NEAREST_EN defined, NORM SHALL round to nearest, ties to even, using guard, round and sticky bits; mantissa carry-out SHALL renormalise and may trigger REQ-020.
REQ-025 Without FP_ACC_ROUND_NEAREST_EN, NORM SHALL truncate (round toward zero) and discard guard, round and sticky bits.

Structure
REQ-026 Package fp_acc_pkg SHALL hold the state enum, the FP32 field widths (1/8/23), BIAS=127, and the constants POS_ZERO, POS_INF and QNAN=0x7FC00000.
REQ-027 Sub-module fp_lzc SHALL be a 27-bit combinational leading-zero counter used by NORM.

Verification
REQ-028 Terms 0x3F800000 then 0x40000000 (last) -> acc_data=0x40400000, with acc_valid rising 4 cycles after the last accept.
REQ-029 Terms 0x3FC00000 then 0xBFC00000 (last) -> 0x00000000; terms 0x3F000000 then 0x3E800000 (last) -> 0x3F400000.
REQ-030 Terms 0x7F7FFFFF then 0x7F7FFFFF (last) -> 0x7F800000; terms 0x7F800000 then 0xFF800000 (last) -> 0x7FC00000.
REQ-031 Terms 0x3F800000 then 0x33C00000 (last) -> 0x3F800001 with the macro defined, 0x3F800000 without it.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> acc_valid and acc_data stable and in_ready=0; assert rst during ALIGN -> next sum starts from +0.

Source files
------------

// File: rtl/fp_acc_pkg.sv
// Shared FP32 field widths, special encodings and FSM state type for fp_accumulator.
package fp_acc_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;

  // Significand with hidden bit, then extended by guard, round and sticky.
  localparam int SIG_W     = MANT_W + 1;
  localparam int EXT_W     = SIG_W + 3;
  localparam int SHIFT_MAX = EXT_W - 1;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/fp_lzc.sv
// 27-bit combinational leading-zero counter; an all-zero input returns 27.
module fp_lzc
  import fp_acc_pkg::*;
(
  input  logic [EXT_W-1:0] value,
  output logic [4:0]       count
);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    count = 5'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (value[i]) count = 5'(EXT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle FP32 accumulator: IDLE -> ALIGN -> ADD -> NORM per term, DONE after the last.
// Define FP_ACC_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module fp_accumulator
  import fp_acc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        acc_valid,
  output logic [31:0] acc_data,
  input  logic        out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, and acc_valid holds with stable acc_data until out_ready.
  state_e state_q, state_n;

  logic [31:0]      term_q, acc_q, special_val_q;
  logic             last_q, special_q, sign_q, sub_q;
  logic [EXT_W-1:0] big_q, small_q;
  logic [EXP_W-1:0] exp_q;
  logic [EXT_W:0]   sum_q;
  logic             accept;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign acc_valid = (state_q == DONE) && !rst;
  assign acc_data  = acc_valid ? acc_q : POS_ZERO;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = ALIGN;
      ALIGN:   state_n = ADD;
      ADD:     state_n = NORM;
      NORM:    state_n = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ALIGN: operand a is the running sum, operand b the captured term.
  logic [EXP_W-1:0]  ea, eb, big_exp, small_exp, exp_diff;
  logic [MANT_W-1:0] ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf, a_ge_b, spec_nan, spec_any, res_sign;
  logic [30:0]       a_mag, b_mag;
  logic [SIG_W-1:0]  a_sig, b_sig, big_sig, small_sig;
  logic [EXT_W-1:0]  small_ext, small_al, lost_mask;
  logic [31:0]       spec_val;

  assign ea = acc_q[30:23];
  assign eb = term_q[30:23];
  assign ma = acc_q[MANT_W-1:0];
  assign mb = term_q[MANT_W-1:0];

  assign a_nan = (ea == 8'hFF) && (ma != '0);
  assign b_nan = (eb == 8'hFF) && (mb != '0);
  assign a_inf = (ea == 8'hFF) && (ma == '0);
  assign b_inf = (eb == 8'hFF) && (mb == '0);

  assign spec_nan = a_nan || b_nan || (a_inf && b_inf && (acc_q[31] != term_q[31]));
  assign spec_any = spec_nan || a_inf || b_inf;
  assign spec_val = spec_nan ? QNAN :
                    a_inf    ? {acc_q[31], POS_INF[30:0]} : {term_q[31], POS_INF[30:0]};

  // Exponent 0 (zero or denormal) contributes nothing to magnitude or significand.
  assign a_mag = (ea == '0) ? 31'd0 : acc_q[30:0];
  assign b_mag = (eb == '0) ? 31'd0 : term_q[30:0];
  assign a_sig = (ea == '0) ? '0 : {1'b1, ma};
  assign b_sig = (eb == '0) ? '0 : {1'b1, mb};

  assign a_ge_b    = a_mag >= b_mag;
  assign big_sig   = a_ge_b ? a_sig : b_sig;
  assign small_sig = a_ge_b ? b_sig : a_sig;
  assign big_exp   = a_ge_b ? ea : eb;
  assign small_exp = a_ge_b ? eb : ea;
  assign res_sign  = a_ge_b ? acc_q[31] : term_q[31];
  assign exp_diff  = big_exp - small_exp;

  always_comb begin
    small_ext = {small_sig, 3'b000};
    lost_mask = ~({EXT_W{1'b1}} << exp_diff);
    if (exp_diff >= EXP_W'(SHIFT_MAX))
      small_al = {{(EXT_W-1){1'b0}}, |small_sig};
    else
      small_al = (small_ext >> exp_diff) | {{(EXT_W-1){1'b0}}, |(small_ext & lost_mask)};
  end

  // NORM: carry-out shifts right once, otherwise shift left by the leading-zero count.
  logic [4:0]         lz;
  logic [EXT_W-1:0]   norm_val;
  logic [SIG_W-1:0]   n_sig;
  logic [SIG_W:0]     rounded;
  logic [MANT_W-1:0]  mant;
  logic               round_up;
  logic signed [9:0]  exp_n, exp_f;
  logic [31:0]        norm_result;

  fp_lzc u_lzc (
    .value (sum_q[EXT_W-1:0]),
    .count (lz)
  );

  always_comb begin
    if (sum_q[EXT_W]) begin
      norm_val = {sum_q[EXT_W:2], |sum_q[1:0]};
      exp_n    = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      norm_val = sum_q[EXT_W-1:0] << lz;
      exp_n    = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
    end
    n_sig = SIG_W'(norm_val >> 3);
`ifdef FP_ACC_ROUND_NEAREST_EN
    round_up = norm_val[2] & (norm_val[1] | norm_val[0] | norm_val[3]);
`else
    round_up = 1'b0;
`endif
    rounded = {1'b0, n_sig} + {{SIG_W{1'b0}}, round_up};
    exp_f   = exp_n + $signed({9'b0, rounded[SIG_W]});
    mant    = rounded[SIG_W] ? rounded[SIG_W-1:1] : rounded[MANT_W-1:0];
    if (special_q)
      norm_result = special_val_q;
    else if ((sum_q == '0) || (exp_n < 10'sd1))
      norm_result = POS_ZERO;
    else if (exp_f >= $signed(10'(EXP_MAX)))
      norm_result = {sign_q, POS_INF[30:0]};
    else
      norm_result = {sign_q, exp_f[EXP_W-1:0], mant};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      term_q        <= '0;
      last_q        <= 1'b0;
      acc_q         <= POS_ZERO;
      special_q     <= 1'b0;
      special_val_q <= '0;
      big_q         <= '0;
      small_q       <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      sub_q         <= 1'b0;
      sum_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            term_q <= in_data;
            last_q <= in_last;
          end
        end
        ALIGN: begin
          special_q     <= spec_any;
          special_val_q <= spec_val;
          big_q         <= {big_sig, 3'b000};
          small_q       <= small_al;
          exp_q         <= big_exp;
          sign_q        <= res_sign;
          sub_q         <= acc_q[31] ^ term_q[31];
        end
        ADD: begin
          if (sub_q) sum_q <= {1'b0, big_q - small_q};
          else       sum_q <= {1'b0, big_q} + {1'b0, small_q};
        end
        NORM:    acc_q <= norm_result;
        DONE:    if (out_ready) acc_q <= POS_ZERO;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: exact big-integer reference model, directed and random sums.
module tb_fp_accumulator;

  logic        clk, rst;
  logic        in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic        acc_valid, out_ready;
  logic [31:0] acc_data;

  int vectors     = 0;
  int miscompares = 0;
  bit force_low   = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] term_buf [8];

  fp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .out_ready (out_ready)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  // Reference: exact sum as an integer in units of 2^-149, then rounded back to FP32.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic [279:0] ma, mb, m;
    logic [24:0]  sig;
    logic         s, a_nan, b_nan, a_inf, b_inf, up;
    int           p, e, sh;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC00000;
    if (a_inf) return {a[31], 31'h7F800000};
    if (b_inf) return {b[31], 31'h7F800000};
    ma = 280'({1'b1, a[22:0]});
    mb = 280'({1'b1, b[22:0]});
    ma = (a[30:23] == 0) ? 280'd0 : (ma << (int'(a[30:23]) - 1));
    mb = (b[30:23] == 0) ? 280'd0 : (mb << (int'(b[30:23]) - 1));
    if (a[31] == b[31]) begin m = ma + mb; s = a[31]; end
    else if (ma >= mb)  begin m = ma - mb; s = a[31]; end
    else                begin m = mb - ma; s = b[31]; end
    if (m == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 280; i++) if (m[i]) p = i;
    e = p - 22;
    if (e < 1) return 32'h0;
    sh  = p - 23;
    sig = 25'(m >> sh);
    up  = 1'b0;
`ifdef FP_ACC_ROUND_NEAREST_EN
    if (sh > 0) begin
      logic [279:0] one, rem, half;
      one  = 280'd1;
      rem  = m & ((one << sh) - one);
      half = one << (sh - 1);
      up   = (rem > half) || ((rem == half) && sig[0]);
    end
`endif
    sig = sig + 25'(up);
    if (sig[24]) begin sig = sig >> 1; e++; end
    if (e >= 255) return {s, 31'h7F800000};
    return {s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_term();
    logic        s;
    logic [22:0] m;
    int          k;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    k = $urandom_range(0, 39);
    if (k == 0) return {s, 8'h00, m};
    if (k == 1) return {s, 8'hFF, 23'h0};
    if (k == 2) return {s, 8'hFF, m | 23'h1};
    if (k <= 5) return {s, 8'($urandom_range(248, 254)), m};
    if (k <= 7) return {s, 8'($urandom_range(1, 4)), m};
    return {s, 8'($urandom_range(118, 136)), m};
  endfunction

  // Consumer: random out_ready, or held low on request.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Compare process: every negedge, outputs against the scoreboard and handshake timing.
  initial begin
    int  cyc = 0;
    int  term_cyc = -100;
    int  last_cyc = -100;
    bit  term_last = 1'b0;
    bit  prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        term_cyc   = -100;
        last_cyc   = -100;
        prev_valid = 1'b0;
      end else begin
        if (acc_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: got acc_valid=1 acc_data=%08h expected no result", acc_data);
          end else begin
            check("acc_data", acc_data, exp_q[0]);
            check("ready_in_done", {31'b0, in_ready}, 32'd0);
            if (!prev_valid) check("valid_latency", 32'(cyc - last_cyc), 32'd4);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        if ((cyc > term_cyc) && (cyc < term_cyc + 4))
          check("ready_busy", {31'b0, in_ready}, 32'd0);
        if ((cyc == term_cyc + 4) && !term_last)
          check("ready_return", {31'b0, in_ready}, 32'd1);
        if (in_valid && in_ready) begin
          term_cyc  = cyc;
          term_last = in_last;
          if (in_last) last_cyc = cyc;
        end
        prev_valid = acc_valid;
      end
    end
  end

  // Driver tasks.
  task automatic send_term(input logic [31:0] d, input bit last);
    int waited = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      waited++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_sum(input int n, input bit pin, input logic [31:0] pin_val);
    logic [31:0] m = 32'h0;
    for (int i = 0; i < n; i++) m = model_add(m, term_buf[i]);
    if (pin) check("model_pin", m, pin_val);
    exp_q.push_back(m);
    for (int i = 0; i < n; i++) send_term(term_buf[i], i == n - 1);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] m;
    int n, waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, acc_valid}, 32'd0);
    check("rst_data", acc_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed sums with hand-computed results.
    term_buf[0] = 32'h3F800000; term_buf[1] = 32'h40000000; run_sum(2, 1'b1, 32'h40400000);
    term_buf[0] = 32'h3FC00000; term_buf[1] = 32'hBFC00000; run_sum(2, 1'b1, 32'h00000000);
    term_buf[0] = 32'h3F000000; term_buf[1] = 32'h3E800000; run_sum(2, 1'b1, 32'h3F400000);
    term_buf[0] = 32'h7F7FFFFF; term_buf[1] = 32'h7F7FFFFF; run_sum(2, 1'b1, 32'h7F800000);
    term_buf[0] = 32'h7F800000; term_buf[1] = 32'hFF800000; run_sum(2, 1'b1, 32'h7FC00000);
`ifdef FP_ACC_ROUND_NEAREST_EN
    term_buf[0] = 32'h3F800000; term_buf[1] = 32'h33C00000; run_sum(2, 1'b1, 32'h3F800001);
`else
    term_buf[0] = 32'h3F800000; term_buf[1] = 32'h33C00000; run_sum(2, 1'b1, 32'h3F800000);
`endif
    term_buf[0] = 32'h7F800000; term_buf[1] = 32'hC0000000; term_buf[2] = 32'h3F800000;
    run_sum(3, 1'b1, 32'h7F800000);
    term_buf[0] = 32'h00400000; term_buf[1] = 32'hBF800000; run_sum(2, 1'b1, 32'hBF800000);
    drain();

    // Back-pressure: hold out_ready low for 5 cycles in DONE.
    force_low = 1'b1;
    term_buf[0] = 32'h3F800000; term_buf[1] = 32'h40000000; run_sum(2, 1'b1, 32'h40400000);
    waited = 0;
    while (!acc_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (5) @(negedge clk);
    check("hold_valid", {31'b0, acc_valid}, 32'd1);
    check("hold_data", acc_data, 32'h40400000);
    force_low = 1'b0;
    drain();

    // Reset during ALIGN discards the partial sum.
    send_term(32'h40000000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, acc_valid}, 32'd0);
    check("mid_rst_data", acc_data, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_rst", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    term_buf[0] = 32'h3F800000; run_sum(1, 1'b1, 32'h3F800000);
    drain();

    // Randomised sums, with occasional exact cancellation of the running total.
    for (int s = 0; s < 60; s++) begin
      n = $urandom_range(1, 6);
      m = 32'h0;
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 4) == 0) term_buf[i] = {~m[31], m[30:0]};
        else                                   term_buf[i] = rand_term();
        m = model_add(m, term_buf[i]);
      end
      run_sum(n, 1'b0, 32'h0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
